// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Frame format and receiver state encodings, common to the
//                UART transmitter and receiver.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : 1-bit two-flop synchroniser. Resets to 1 so that an idle-high
//                serial line never looks like a start bit coming out of reset.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first stage a cycle to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : UART receiver, 8N1, LSB first, idle-high line. Samples every
//                bit at its centre and reports each good byte with a one-cycle
//                valid strobe, or a one-cycle frame_err if the stop bit is low.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      valid,
    output logic                      frame_err,
    output logic                      busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] c_HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] c_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       c_IDX_LAST  = 3'(UART_DATA_BITS - 1);

    logic                      w_rx_s;

    uart_state_e               state_q,   state_d;
    logic [CNT_W-1:0]          cnt_q,     cnt_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q,   shift_d;
    logic [UART_DATA_BITS-1:0] data_q,    data_d;
    logic                      valid_q,   valid_d;
    logic                      ferr_q,    ferr_d;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (w_rx_s)
    );

    // State, counters, shift register and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    // Frame sequencing: half a bit to the start-bit centre, then one full bit
    // period between consecutive samples.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!w_rx_s) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (cnt_q == c_HALF_LAST) begin
                    cnt_d = '0;
                    if (!w_rx_s) begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                    end else begin
                        // Line went back high before mid start bit: a glitch.
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (cnt_q == c_BIT_LAST) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = w_rx_s;
                    if (bit_idx_q == c_IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_STOP: begin
                if (cnt_q == c_BIT_LAST) begin
                    cnt_d = '0;
                    if (w_rx_s) begin
                        // Returning to IDLE at mid-stop lets a start bit that
                        // directly follows the stop bit be caught.
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_BREAK: begin
                // Hold here while the line stays low so a break gives one error.
                cnt_d = '0;
                if (w_rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. A bit-level serial sender
//                drives two receivers (8 and 104 clocks per bit); received
//                bytes and frame errors are compared with a frame-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB   = 8;
    localparam int CPB_L = 104;

    logic       clk;
    logic       rst;
    logic       rx8;
    logic       rx104;
    logic [7:0] data8,  data104;
    logic       valid8, valid104;
    logic       ferr8,  ferr104;
    logic       busy8,  busy104;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Observed events
    logic [7:0] got8[$];
    logic [7:0] got104[$];
    int ferr8_cnt   = 0;
    int ferr104_cnt = 0;
    int both_cnt    = 0;
    int wide_cnt    = 0;
    int t_valid     = -1;
    int t_start     = 0;
    logic busy_seen = 1'b0;
    logic prev_v8   = 1'b0;
    logic prev_f8   = 1'b0;

    // Frame-level reference model
    logic [7:0] exp8[$];
    int         exp_ferr  = 0;
    logic [7:0] last_data = 8'h00;

    uart_rx #(.CLKS_PER_BIT(CPB)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx8),
        .data      (data8),
        .valid     (valid8),
        .frame_err (ferr8),
        .busy      (busy8)
    );

    uart_rx #(.CLKS_PER_BIT(CPB_L)) u_dut104 (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx104),
        .data      (data104),
        .valid     (valid104),
        .frame_err (ferr104),
        .busy      (busy104)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (valid8) begin
            got8.push_back(data8);
            t_valid = cyc;
        end
        if (ferr8)                                         ferr8_cnt++;
        if (valid8 && ferr8)                               both_cnt++;
        if ((valid8 && prev_v8) || (ferr8 && prev_f8))     wide_cnt++;
        prev_v8 = valid8;
        prev_f8 = ferr8;
        if (busy8) busy_seen = 1'b1;
        if (valid104) got104.push_back(data104);
        if (ferr104)  ferr104_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v);
        if (sel == 0) rx8 = v;
        else          rx104 = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame, LSB first; called and returns on a falling edge.
    task automatic send_frame(input int sel, input logic [7:0] b, input int bit_cyc,
                              input logic stop_val, input int stop_cyc);
        drive(sel, 1'b0);
        if (sel == 0) t_start = cyc;
        idle(bit_cyc);
        for (int i = 0; i < 8; i++) begin
            drive(sel, b[i]);
            idle(bit_cyc);
        end
        drive(sel, stop_val);
        idle(stop_cyc);
        drive(sel, 1'b1);
    endtask

    task automatic send_good(input logic [7:0] b, input int gap);
        send_frame(0, b, CPB, 1'b1, CPB);
        exp8.push_back(b);
        last_data = b;
        idle(gap);
    endtask

    task automatic compare_frames(input string tag);
        check({tag, "_count"}, 32'(got8.size()), 32'(exp8.size()));
        for (int i = 0; i < exp8.size(); i++)
            if (i < got8.size()) check({tag, "_byte"}, 32'(got8[i]), 32'(exp8[i]));
        check({tag, "_ferr"}, 32'(ferr8_cnt), 32'(exp_ferr));
        check({tag, "_held"}, 32'(data8), 32'(last_data));
        got8.delete();
        exp8.delete();
    endtask

    initial begin
        logic busy_after;
        logic [7:0] b;
        int gap;

        rst   = 1'b1;
        rx8   = 1'b1;
        rx104 = 1'b1;
        idle(3);

        // Reset state
        check("rst_data",  32'(data8),   32'h0);
        check("rst_valid", 32'(valid8),  32'h0);
        check("rst_ferr",  32'(ferr8),   32'h0);
        check("rst_busy",  32'(busy8),   32'h0);
        check("rst_data104", 32'(data104), 32'h0);
        rst = 1'b0;
        busy_after = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            busy_after = busy_after | busy8;
        end
        check("post_rst_busy", 32'(busy_after), 32'h0);

        // Single frame and its latency (HALF + 9*CPB + 3)
        send_good(8'hA5, 3 * CPB);
        compare_frames("a5");
        check("latency", 32'(t_valid - t_start), 32'(CPB / 2 + 9 * CPB + 3));

        // Back-to-back frames with zero idle gap
        send_good(8'h00, 0);
        send_good(8'hFF, 0);
        send_good(8'h5A, 3 * CPB);
        compare_frames("b2b");

        // Short low glitch on an idle line
        busy_seen = 1'b0;
        rx8 = 1'b0;
        idle(3);
        rx8 = 1'b1;
        idle(3 * CPB);
        check("glitch_entered", 32'(busy_seen), 32'h1);
        check("glitch_busy", 32'(busy8), 32'h0);
        compare_frames("glitch");

        // Stop bit held low for 20 bit periods: one frame error, data held
        send_frame(0, 8'h3C, CPB, 1'b0, 20 * CPB);
        exp_ferr++;
        idle(2 * CPB);
        compare_frames("break");
        send_good(8'h81, 3 * CPB);
        compare_frames("after_break");

        // Reset in the middle of data bit 4 of 0x77
        rx8 = 1'b0;
        idle(CPB);
        b = 8'h77;
        for (int i = 0; i < 4; i++) begin
            rx8 = b[i];
            idle(CPB);
        end
        rx8 = b[4];
        idle(CPB / 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx8 = 1'b1;
        last_data = 8'h00;
        check("midrst_data", 32'(data8), 32'h0);
        check("midrst_busy", 32'(busy8), 32'h0);
        idle(3 * CPB);
        compare_frames("midrst");
        send_good(8'h12, 3 * CPB);
        compare_frames("after_rst");

        // Randomised traffic, occasional bad stop bit
        for (int n = 0; n < 24; n++) begin
            b   = 8'($urandom_range(0, 255));
            gap = $urandom_range(0, 2 * CPB);
            if ($urandom_range(0, 4) == 0) begin
                send_frame(0, b, CPB, 1'b0, CPB);
                exp_ferr++;
                idle(CPB + gap);
            end else begin
                send_good(b, gap);
            end
        end
        idle(3 * CPB);
        compare_frames("random");

        // 104 clocks per bit with the sender running 3% slow and 3% fast
        send_frame(1, 8'hC3, 107, 1'b1, 107);
        idle(3 * CPB_L);
        send_frame(1, 8'hC3, 101, 1'b1, 101);
        idle(3 * CPB_L);
        check("skew_count", 32'(got104.size()), 32'd2);
        for (int i = 0; i < got104.size(); i++)
            check("skew_byte", 32'(got104[i]), 32'hC3);
        check("skew_ferr", 32'(ferr104_cnt), 32'h0);

        // Pulse integrity across the whole run
        check("valid_and_ferr", 32'(both_cnt), 32'h0);
        check("pulse_width",    32'(wide_cnt), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
